mod120833_mul_frontend: RTL and testbench

//  Issue side of the mod-120833 datapath. Takes pairs of centred residues over valid/ready
//  and multiplies them. Each 33-bit signed product drives the external modmul120833s

---
 rtl/mod120833_mul_frontend.sv | 119 +++++++++++
 tb/tb_mod120833_mul_frontend.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod120833_mul_frontend.sv
// Issue side of the mod-120833 datapath: operand multiply, reducer-valid tracking,
// centred normalisation of the reducer result and a credit-protected result FIFO.
module mod120833_mul_frontend #(
   parameter int DATA_W     = 17,
   parameter int PROD_W     = 33,
   parameter int Q          = 120833,
   parameter int QH         = 60416,
   parameter int RED_LAT    = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_a,
   input  logic signed [DATA_W-1:0] in_b,
   output logic signed [PROD_W-1:0] red_inZ,
   input  logic signed [DATA_W-1:0] red_outZ,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_z,
   output logic                     err_range
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic signed [DATA_W-1:0] QH_D = DATA_W'(QH);
   localparam logic signed [DATA_W:0]   QH_W = (DATA_W + 1)'(QH);
   localparam logic signed [DATA_W:0]   Q_W  = (DATA_W + 1)'(Q);

   function automatic logic in_centred(input logic signed [DATA_W-1:0] v);
      return (v >= -QH_D) && (v <= QH_D);
   endfunction

   function automatic logic signed [PROD_W-1:0] mul_trunc(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [2*DATA_W-1:0] p;
      p = a * b;
      return p[PROD_W-1:0];
   endfunction

   // The reducer may be off by one modulus in either direction; one step recentres it.
   function automatic logic signed [DATA_W-1:0] norm_centre(input logic signed [DATA_W-1:0] n);
      logic signed [DATA_W:0] w;
      w = {n[DATA_W-1], n};
      if (w > QH_W)
         w = w - Q_W;
      else if (w < -QH_W)
         w = w + Q_W;
      return w[DATA_W-1:0];
   endfunction

   logic                   accept;
   logic                   push;
   logic                   pop;
   logic [RED_LAT:0]       vld_p;
   logic [CNT_W-1:0]       used;
   logic [PTR_W:0]         wr_ptr;
   logic [PTR_W:0]         rd_ptr;
   logic signed [DATA_W-1:0] mem [FIFO_DEPTH];

   assign in_ready  = rst_n && (used < CNT_W'(FIFO_DEPTH));
   assign accept    = in_valid && in_ready;
   assign push      = vld_p[RED_LAT];
   assign out_valid = (wr_ptr != rd_ptr);
   assign pop       = out_valid && out_ready;
   assign out_z     = out_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;

   // Issue stage: product into the reducer, valid bit follows it down the fixed latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red_inZ   <= '0;
         vld_p     <= '0;
         err_range <= 1'b0;
      end else begin
         vld_p <= {vld_p[RED_LAT-1:0], accept};
         if (accept) begin
            red_inZ <= mul_trunc(in_a, in_b);
            if (!in_centred(in_a) || !in_centred(in_b))
               err_range <= 1'b1;
         end
      end
   end

   // Credits count every op between accept and pop, so a FIFO slot always exists at push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         used <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   used <= used + 1'b1;
            2'b01:   used <= used - 1'b1;
            default: used <= used;
         endcase
      end
   end

   // Capture stage: normalised reducer output enters the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[PTR_W-1:0]] <= norm_centre(red_outZ);
   end

endmodule

// File: tb/tb_mod120833_mul_frontend.sv
// Randomised and directed bench for mod120833_mul_frontend with a behavioural reducer
// model and a queue scoreboard of centred products.
module tb_mod120833_mul_frontend;

   localparam longint Q  = 120833;
   localparam longint QH = 60416;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [16:0] in_a;
   logic signed [16:0] in_b;
   logic signed [32:0] red_inZ;
   logic signed [16:0] red_outZ;
   logic               out_valid;
   logic               out_ready;
   logic signed [16:0] out_z;
   logic               err_range;

   always #5 clk = ~clk;

   mod120833_mul_frontend dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .red_inZ   (red_inZ),
      .red_outZ  (red_outZ),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .err_range (err_range)
   );

   typedef struct {
      longint exp;
      bit     dc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_acc  = 0;
   int   n_pop  = 0;
   int   red_mode = 0;  // 0 random alias, 1 force +Q alias, 2 force -Q alias

   function automatic longint centred(input longint p);
      longint c;
      c = p % Q;
      if (c < 0) c = c + Q;
      if (c > QH) c = c - Q;
      return c;
   endfunction

   function automatic bit in_rng(input longint v);
      return (v >= -QH) && (v <= QH);
   endfunction

   // Reducer: any 17-bit representative congruent to the product.
   function automatic logic signed [16:0] reducer_out(input logic signed [32:0] z, input int mode);
      longint c, hi, lo;
      bit hi_ok, lo_ok;
      int pick;
      c     = centred(longint'(z));
      hi    = c + Q;
      lo    = c - Q;
      hi_ok = (hi <= 65535);
      lo_ok = (lo >= -65536);
      if (mode == 1 && hi_ok) return 17'(hi);
      if (mode == 2 && lo_ok) return 17'(lo);
      if (mode == 0) begin
         pick = int'($urandom_range(2));
         if (pick == 1 && hi_ok) return 17'(hi);
         if (pick == 2 && lo_ok) return 17'(lo);
      end
      return 17'(c);
   endfunction

   logic signed [16:0] r1, r2, r3;
   assign red_outZ = r3;
   always @(posedge clk) begin
      r1 <= reducer_out(red_inZ, red_mode);
      r2 <= r1;
      r3 <= r2;
   end

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Issue monitor: handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         exp_t e;
         e.exp = centred(longint'(in_a) * longint'(in_b));
         e.dc  = !in_rng(longint'(in_a)) || !in_rng(longint'(in_b));
         sb.push_back(e);
         n_acc++;
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_pop++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got out_z=%0d, expected no pending result", out_z);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (!e.dc) check("out_z", longint'(out_z), e.exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_operands();
      in_a = 17'(longint'($urandom_range(2 * QH)) - QH);
      in_b = 17'(longint'($urandom_range(2 * QH)) - QH);
   endtask

   task automatic issue1(input longint a, input longint b);
      bit acc;
      acc      = 1'b0;
      in_a     = 17'(a);
      in_b     = 17'(b);
      in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) check("issue_timeout", 0, 1);
   endtask

   task automatic expect_next(input string name, input longint req);
      int k;
      k = 0;
      while (!out_valid && k < 50) begin
         step();
         k++;
      end
      check({name, "_valid"}, longint'(out_valid), 1);
      check(name, longint'(out_z), req);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((sb.size() != 0 || out_valid) && k < 1000) begin
         step();
         k++;
      end
      check("drain_pending", longint'(sb.size()), 0);
   endtask

   initial begin
      int k, a0, p0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      #3;
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_z", longint'(out_z), 0);
      check("rst_red_inZ", longint'(red_inZ), 0);
      check("rst_err_range", longint'(err_range), 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      check("post_rst_in_ready", longint'(in_ready), 1);

      // Latency of a single op.
      issue1(1, 1);
      k = 0;
      while (!out_valid && k < 20) begin
         step();
         k++;
      end
      check("latency_edges", k, 4);
      check("one_times_one", longint'(out_z), 1);
      drain();

      issue1(60416, 60416);
      expect_next("max_sq", -30208);
      drain();
      issue1(-60416, 60416);
      expect_next("neg_max_sq", 30208);
      drain();
      issue1(0, -5);
      expect_next("zero_prod", 0);
      drain();

      // Reducer aliases at the edges of the normaliser.
      red_mode = 1;
      issue1(-1, 60416);
      expect_next("alias_plus_q", -60416);
      drain();
      red_mode = 2;
      issue1(1, 60416);
      expect_next("alias_minus_q", 60416);
      drain();
      red_mode = 0;

      // Backpressure: exactly FIFO_DEPTH accepts.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a0 = n_acc;
      for (int i = 0; i < 30; i++) begin
         rand_operands();
         step();
      end
      check("bp_accepts", n_acc - a0, 8);
      check("bp_in_ready", longint'(in_ready), 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      p0 = n_pop;
      for (int i = 0; i < 12; i++) step();
      check("bp_pops", n_pop - p0, 8);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rand_operands();
         step();
      end
      a0 = n_acc;
      for (int i = 0; i < 20; i++) begin
         rand_operands();
         step();
      end
      check("stream_rate", n_acc - a0, 20);
      in_valid = 1'b0;
      drain();

      // Reset with ops in flight.
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_operands();
         step();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_in_ready", longint'(in_ready), 0);
      check("midrst_red_inZ", longint'(red_inZ), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      issue1(2, 3);
      expect_next("after_rst", 6);
      drain();

      // Random traffic with random backpressure and reducer aliases.
      for (int i = 0; i < 6000; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         if ($urandom_range(15) == 0) begin
            in_a = ($urandom_range(1) != 0) ? 17'(QH) : 17'(-QH);
            in_b = ($urandom_range(1) != 0) ? 17'(QH) : 17'(-QH);
         end else begin
            rand_operands();
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Out-of-range operand sets the sticky flag.
      check("err_before", longint'(err_range), 0);
      issue1(60417, 1);
      check("err_set", longint'(err_range), 1);
      issue1(5, 7);
      for (int i = 0; i < 5; i++) step();
      check("err_sticky", longint'(err_range), 1);
      drain();
      #2 rst_n = 1'b0;
      #1;
      check("err_cleared", longint'(err_range), 0);
      sb.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
